// File: rtl/flaf_trig_expander.sv
// flaf_trig_expander: feeds k*pi*x angles to a cosine block and streams the
// expansion [x, sin(pi x), cos(pi x), ...]. Optional macro: FLAF_TRIG_COSREG_EN.
module flaf_trig_expander #(
    parameter int ORDER = 3,
    parameter int IDX_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [15:0]       x_in,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic signed [16:0]       theta_out,
    input  logic signed [15:0]       cos_in,
    output logic signed [15:0]       feat_out,
    output logic [IDX_W-1:0]         feat_idx,
    output logic                     feat_valid,
    input  logic                     feat_ready,
    output logic                     feat_last,
    output logic                     clamp_flag
);

    localparam int KW = 3;

    localparam logic signed [17:0] PI   = 18'sh03244;
    localparam logic signed [17:0] PIB2 = 18'sh01922;
    localparam logic signed [17:0] PIM2 = 18'sh06487;
    localparam logic signed [15:0] XMAX = 16'sh1000;
    localparam logic signed [15:0] XMIN = -16'sh1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_EMIT_X,
        S_EMIT_SIN,
        S_EMIT_COS
`ifdef FLAF_TRIG_COSREG_EN
        , S_WAIT
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

`ifdef FLAF_TRIG_COSREG_EN
    state_t             r_wret;
    state_t             w_wret;
    logic signed [15:0] r_cos;
`endif

    logic signed [15:0] r_xc;
    logic               r_clamp;
    logic signed [17:0] r_pix;
    logic signed [17:0] r_acc;
    logic signed [16:0] r_theta;
    logic [KW-1:0]      r_k;

    logic signed [15:0] w_xc;
    logic signed [32:0] w_prod;
    logic signed [17:0] w_pix;
    logic signed [17:0] w_sum;
    logic signed [17:0] w_wrap;
    logic signed [15:0] w_cosv;
    logic [IDX_W-1:0]   w_idx2k;
    logic               w_last;
    logic               w_take_x;
    logic               w_mul_done;
    logic               w_to_cos;
    logic               w_to_sin;

    assign theta_out  = r_theta;
    assign clamp_flag = r_clamp;

    // Saturate the incoming sample to [-1.0, +1.0]
    always_comb begin
        w_xc = x_in;
        if (x_in > XMAX) begin
            w_xc = XMAX;
        end else if (x_in < XMIN) begin
            w_xc = XMIN;
        end
    end

    // pi*x with floor rounding; next harmonic folded back into (-2pi, 2pi)
    always_comb begin
        w_prod = 33'(r_xc) * 33'(PI);
        w_pix  = 18'(w_prod >>> 12);
        w_sum  = r_acc + r_pix;
        w_wrap = w_sum;
        if (w_sum >= PIM2) begin
            w_wrap = w_sum - PIM2;
        end else if (w_sum <= -PIM2) begin
            w_wrap = w_sum + PIM2;
        end
    end

    // Term index, last-harmonic flag and the cosine value presented on beats
    always_comb begin
        w_idx2k = IDX_W'({r_k, 1'b0});
        w_last  = (r_k == KW'(ORDER));
`ifdef FLAF_TRIG_COSREG_EN
        w_cosv  = r_cos;
`else
        w_cosv  = cos_in;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
`ifdef FLAF_TRIG_COSREG_EN
            r_wret  <= S_IDLE;
`endif
        end else begin
            r_state <= w_next;
`ifdef FLAF_TRIG_COSREG_EN
            r_wret  <= w_wret;
`endif
        end
    end

    // Next state, stream outputs and datapath load strobes
    always_comb begin
        w_next     = r_state;
`ifdef FLAF_TRIG_COSREG_EN
        w_wret     = r_wret;
`endif
        x_ready    = 1'b0;
        feat_valid = 1'b0;
        feat_out   = '0;
        feat_idx   = '0;
        feat_last  = 1'b0;
        w_take_x   = 1'b0;
        w_mul_done = 1'b0;
        w_to_cos   = 1'b0;
        w_to_sin   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                x_ready = reset;
                if (x_valid) begin
                    w_take_x = 1'b1;
                    w_next   = S_MUL;
                end
            end
            S_MUL: begin
                w_mul_done = 1'b1;
`ifdef FLAF_TRIG_COSREG_EN
                w_next = S_WAIT;
                w_wret = S_EMIT_X;
`else
                w_next = S_EMIT_X;
`endif
            end
            S_EMIT_X: begin
                feat_valid = 1'b1;
                feat_out   = r_xc;
                if (feat_ready) begin
                    w_next = S_EMIT_SIN;
                end
            end
            S_EMIT_SIN: begin
                feat_valid = 1'b1;
                feat_out   = w_cosv;
                feat_idx   = w_idx2k - IDX_W'(1);
                if (feat_ready) begin
                    w_to_cos = 1'b1;
`ifdef FLAF_TRIG_COSREG_EN
                    w_next = S_WAIT;
                    w_wret = S_EMIT_COS;
`else
                    w_next = S_EMIT_COS;
`endif
                end
            end
            S_EMIT_COS: begin
                feat_valid = 1'b1;
                feat_out   = w_cosv;
                feat_idx   = w_idx2k;
                feat_last  = w_last;
                if (feat_ready) begin
                    if (w_last) begin
                        w_next = S_IDLE;
                    end else begin
                        w_to_sin = 1'b1;
`ifdef FLAF_TRIG_COSREG_EN
                        w_next = S_WAIT;
                        w_wret = S_EMIT_SIN;
`else
                        w_next = S_EMIT_SIN;
`endif
                    end
                end
            end
`ifdef FLAF_TRIG_COSREG_EN
            S_WAIT: begin
                w_next = r_wret;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Sample latch, angle accumulator and the angle driven to the cosine block
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_xc    <= '0;
            r_clamp <= 1'b0;
            r_pix   <= '0;
            r_acc   <= '0;
            r_theta <= '0;
            r_k     <= '0;
        end else begin
            if (w_take_x) begin
                r_xc    <= w_xc;
                r_clamp <= (w_xc != x_in);
            end
            if (w_mul_done) begin
                r_pix   <= w_pix;
                r_acc   <= w_pix;
                r_theta <= 17'(w_pix - PIB2);
                r_k     <= KW'(1);
            end
            if (w_to_cos) begin
                r_theta <= 17'(r_acc);
            end
            if (w_to_sin) begin
                r_acc   <= w_wrap;
                r_theta <= 17'(w_wrap - PIB2);
                r_k     <= r_k + KW'(1);
            end
        end
    end

`ifdef FLAF_TRIG_COSREG_EN
    // Capture the pipelined cosine result once theta has settled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cos <= '0;
        end else if (r_state == S_WAIT) begin
            r_cos <= cos_in;
        end
    end
`endif

endmodule

// File: tb/tb_flaf_trig_expander.sv
// tb_flaf_trig_expander: randomized stream checks of flaf_trig_expander
// against an arithmetic model of the expansion, with a stub cosine block.
module tb_flaf_trig_expander;

    localparam int ORDER = 3;
    localparam int IDX_W = 4;
    localparam int NB    = 2 * ORDER + 1;
`ifdef FLAF_TRIG_COSREG_EN
    localparam int XR_CYC = 4 * ORDER + 2;
`else
    localparam int XR_CYC = 2 * ORDER + 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      x_in;
    logic             x_valid;
    logic             x_ready;
    logic [16:0]      theta_out;
    logic [15:0]      cos_in;
    logic [15:0]      feat_out;
    logic [IDX_W-1:0] feat_idx;
    logic             feat_valid;
    logic             feat_ready;
    logic             feat_last;
    logic             clamp_flag;

    int n_pass  = 0;
    int n_total = 0;

    logic [IDX_W-1:0] ob_idx[$];
    logic [15:0]      ob_out[$];
    logic [16:0]      ob_th[$];
    logic             ob_last[$];
    logic             ob_cl[$];
    int               ob_edge[$];
    int               o_unstable;
    int               o_stalls;
    int               o_xr_bad;
    int               o_xr_cyc;
    bit               o_timeout;

    logic [IDX_W-1:0] e_idx[$];
    logic [15:0]      e_out[$];
    logic [16:0]      e_th[$];
    logic             e_last[$];
    logic             e_clamp;

    flaf_trig_expander #(.ORDER(ORDER), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .theta_out  (theta_out),
        .cos_in     (cos_in),
        .feat_out   (feat_out),
        .feat_idx   (feat_idx),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_last  (feat_last),
        .clamp_flag (clamp_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] stub(input logic [16:0] t);
        if (t == 17'd0) return 16'h1000;
        return (t[15:0] ^ 16'h5A5A) + {15'd0, t[16]};
    endfunction

    assign cos_in = stub(theta_out);

    function automatic int exp_edge(input int i);
`ifdef FLAF_TRIG_COSREG_EN
        return (i == 0) ? 3 : 2 + 2 * i;
`else
        return 2 + i;
`endif
    endfunction

    // Expected vector: x, then sin/cos pairs of k*pi*x kept inside (-2pi, 2pi)
    task automatic model(input logic [15:0] x);
        int xi, xc, pix, acc;
        xi = int'($signed(x));
        xc = (xi > 4096) ? 4096 : ((xi < -4096) ? -4096 : xi);
        e_clamp = (xc != xi);
        pix = (xc * 12868) >>> 12;
        e_idx.delete(); e_out.delete(); e_th.delete(); e_last.delete();
        e_idx.push_back('0);
        e_out.push_back(16'(xc));
        e_th.push_back(17'(pix - 6434));
        e_last.push_back(1'b0);
        acc = pix;
        for (int k = 1; k <= ORDER; k++) begin
            if (k > 1) begin
                acc = acc + pix;
                if (acc >= 25735) acc = acc - 25735;
                else if (acc <= -25735) acc = acc + 25735;
            end
            e_idx.push_back(IDX_W'(2 * k - 1));
            e_th.push_back(17'(acc - 6434));
            e_out.push_back(stub(17'(acc - 6434)));
            e_last.push_back(1'b0);
            e_idx.push_back(IDX_W'(2 * k));
            e_th.push_back(17'(acc));
            e_out.push_back(stub(17'(acc)));
            e_last.push_back(k == ORDER);
        end
    endtask

    // Push one sample and collect the beats; mode 0 ready=1, 1 random, 2 1,0,0,1
    task automatic drive_vector(input logic [15:0] x, input int mode);
        int cyc;
        int pat;
        logic [3:0] pbits;
        logic [37:0] prev;
        bit stalled;
        ob_idx.delete(); ob_out.delete(); ob_th.delete();
        ob_last.delete(); ob_cl.delete(); ob_edge.delete();
        o_unstable = 0; o_stalls = 0; o_xr_bad = 0; o_xr_cyc = -1;
        o_timeout = 0; pat = 0; pbits = 4'b1001; stalled = 0; prev = '0;
        feat_ready = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 50 && !x_ready; w++) @(negedge clk);
        if (!x_ready) o_timeout = 1;
        x_in = x;
        x_valid = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        x_valid = 1'b0;
        x_in = 16'($urandom);
        while (1) begin
            if (mode == 0) begin
                feat_ready = 1'b1;
            end else if (mode == 1) begin
                feat_ready = 1'($urandom_range(0, 1));
            end else begin
                if (pat > 0 || (feat_valid && feat_idx == 0)) begin
                    if (pat < 4) begin
                        feat_ready = pbits[3 - pat];
                        pat++;
                    end else begin
                        feat_ready = 1'b1;
                    end
                end else begin
                    feat_ready = 1'b1;
                end
            end
            #1;
            if (stalled && {feat_out, feat_idx, feat_last, theta_out} !== prev)
                o_unstable++;
            if (x_ready && ob_idx.size() < NB) o_xr_bad++;
            if (feat_valid && feat_ready) begin
                ob_idx.push_back(feat_idx);
                ob_out.push_back(feat_out);
                ob_th.push_back(theta_out);
                ob_last.push_back(feat_last);
                ob_cl.push_back(clamp_flag);
                ob_edge.push_back(cyc + 1);
            end
            stalled = feat_valid && !feat_ready;
            if (stalled) o_stalls++;
            prev = {feat_out, feat_idx, feat_last, theta_out};
            if (ob_idx.size() >= NB && x_ready) begin
                o_xr_cyc = cyc;
                break;
            end
            if (cyc >= 400) begin
                o_timeout = 1;
                break;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        feat_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; x_valid = 1'b0; feat_ready = 1'b0; x_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (feat_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", feat_valid);
        else n_pass++;
        n_total++;
        if (theta_out !== 17'd0) $display("FAIL rst_theta got %h want 0", theta_out);
        else n_pass++;
        n_total++;
        if (feat_out !== 16'd0) $display("FAIL rst_out got %h want 0", feat_out);
        else n_pass++;
        n_total++;
        if ({feat_idx, feat_last} !== '0) $display("FAIL rst_idx got %h/%b want 0/0", feat_idx, feat_last);
        else n_pass++;
        n_total++;
        if (clamp_flag !== 1'b0) $display("FAIL rst_clamp got %b want 0", clamp_flag);
        else n_pass++;
        n_total++;
        if (x_ready !== 1'b0) $display("FAIL rst_xready got %b want 0", x_ready);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (x_ready !== 1'b1) $display("FAIL rel_xready got %b want 1", x_ready);
        else n_pass++;
    endtask

    task automatic test_full_rate();
        logic [15:0] xs[3];
        xs[0] = 16'h1000; xs[1] = 16'h0800; xs[2] = 16'hF000;
        for (int s = 0; s < 3; s++) begin
            model(xs[s]);
            drive_vector(xs[s], 0);
            n_total++;
            if (o_timeout || ob_idx.size() != NB)
                $display("FAIL full%0d_count got %0d beats to=%b want %0d", s, ob_idx.size(), o_timeout, NB);
            else n_pass++;
            for (int i = 0; i < ob_idx.size() && i < NB; i++) begin
                n_total++;
                if ({ob_idx[i], ob_out[i], ob_th[i], ob_last[i], ob_cl[i]} !==
                    {e_idx[i], e_out[i], e_th[i], e_last[i], e_clamp} || ob_edge[i] != exp_edge(i))
                    $display("FAIL full%0d_beat%0d got idx=%0d out=%h th=%h last=%b cl=%b edge=%0d want idx=%0d out=%h th=%h last=%b cl=%b edge=%0d",
                             s, i, ob_idx[i], ob_out[i], ob_th[i], ob_last[i], ob_cl[i], ob_edge[i],
                             e_idx[i], e_out[i], e_th[i], e_last[i], e_clamp, exp_edge(i));
                else n_pass++;
            end
            n_total++;
            if (o_xr_cyc != XR_CYC || o_xr_bad != 0)
                $display("FAIL full%0d_xready got cyc=%0d bad=%0d want cyc=%0d bad=0", s, o_xr_cyc, o_xr_bad, XR_CYC);
            else n_pass++;
            if (ob_idx.size() == NB) begin
                case (s)
                    0: begin
                        n_total++;
                        if ({ob_th[1], ob_th[4], ob_th[6]} !== {17'h01922, 17'h00001, 17'h03245})
                            $display("FAIL pos1_theta got %h %h %h want 01922 00001 03245", ob_th[1], ob_th[4], ob_th[6]);
                        else n_pass++;
                    end
                    1: begin
                        n_total++;
                        if ({ob_th[1], ob_out[1], ob_th[2]} !== {17'h00000, 16'h1000, 17'h01922})
                            $display("FAIL half_sin got th=%h out=%h th2=%h want 00000 1000 01922", ob_th[1], ob_out[1], ob_th[2]);
                        else n_pass++;
                    end
                    default: begin
                        n_total++;
                        if ({ob_th[1], ob_th[2], ob_th[4]} !== {17'h1B49A, 17'h1CDBC, 17'h1FFFF})
                            $display("FAIL neg1_theta got %h %h %h want 1b49a 1cdbc 1ffff", ob_th[1], ob_th[2], ob_th[4]);
                        else n_pass++;
                    end
                endcase
            end
        end
    endtask

    task automatic test_clamp();
        logic [15:0] xs[2];
        logic        want[2];
        xs[0] = 16'h2000; xs[1] = 16'h0400;
        want[0] = 1'b1;   want[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            model(xs[s]);
            drive_vector(xs[s], 0);
            n_total++;
            if (ob_idx.size() != NB || ob_cl.size() != NB || ob_cl[0] !== want[s] || ob_cl[NB-1] !== want[s])
                $display("FAIL clamp%0d_flag got n=%0d first=%b want n=%0d flag=%b", s, ob_cl.size(), ob_cl[0], NB, want[s]);
            else n_pass++;
            n_total++;
            if (ob_out.size() != NB || ob_out[0] !== e_out[0])
                $display("FAIL clamp%0d_x got %h want %h", s, ob_out[0], e_out[0]);
            else n_pass++;
            n_total++;
            if (clamp_flag !== want[s])
                $display("FAIL clamp%0d_hold got %b want %b", s, clamp_flag, want[s]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        model(16'h0C00);
        drive_vector(16'h0C00, 2);
        n_total++;
        if (o_timeout || ob_idx.size() != NB)
            $display("FAIL stall_count got %0d beats to=%b want %0d", ob_idx.size(), o_timeout, NB);
        else n_pass++;
        for (int i = 0; i < ob_idx.size() && i < NB; i++) begin
            n_total++;
            if ({ob_idx[i], ob_out[i], ob_th[i], ob_last[i]} !== {e_idx[i], e_out[i], e_th[i], e_last[i]})
                $display("FAIL stall_beat%0d got idx=%0d out=%h th=%h last=%b want idx=%0d out=%h th=%h last=%b",
                         i, ob_idx[i], ob_out[i], ob_th[i], ob_last[i], e_idx[i], e_out[i], e_th[i], e_last[i]);
            else n_pass++;
        end
        n_total++;
        if (o_unstable != 0 || o_stalls != 2)
            $display("FAIL stall_hold got unstable=%0d stalls=%0d want 0 and 2", o_unstable, o_stalls);
        else n_pass++;
        n_total++;
        if (o_xr_bad != 0) $display("FAIL stall_xready got %0d high cycles want 0", o_xr_bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] x;
        for (int s = 0; s < 10; s++) begin
            if (s % 2 == 0) x = 16'($urandom_range(0, 8192)) - 16'h1000;
            else x = 16'($urandom);
            model(x);
            drive_vector(x, 1);
            n_total++;
            if (o_timeout || ob_idx.size() != NB || o_unstable != 0 || o_xr_bad != 0)
                $display("FAIL rand%0d_stream got beats=%0d to=%b unstable=%0d xr=%0d want %0d 0 0 0",
                         s, ob_idx.size(), o_timeout, o_unstable, o_xr_bad, NB);
            else n_pass++;
            for (int i = 0; i < ob_idx.size() && i < NB; i++) begin
                n_total++;
                if ({ob_idx[i], ob_out[i], ob_th[i], ob_last[i], ob_cl[i]} !==
                    {e_idx[i], e_out[i], e_th[i], e_last[i], e_clamp})
                    $display("FAIL rand%0d_beat%0d x=%h got idx=%0d out=%h th=%h last=%b cl=%b want idx=%0d out=%h th=%h last=%b cl=%b",
                             s, i, x, ob_idx[i], ob_out[i], ob_th[i], ob_last[i], ob_cl[i],
                             e_idx[i], e_out[i], e_th[i], e_last[i], e_clamp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midvector();
        bit hit;
        int extra;
        hit = 0;
        extra = 0;
        @(negedge clk);
        for (int w = 0; w < 50 && !x_ready; w++) @(negedge clk);
        x_in = 16'h0A00;
        x_valid = 1'b1;
        feat_ready = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        for (int w = 0; w < 50 && !hit; w++) begin
            if (feat_valid && feat_idx == 3) hit = 1;
            else @(negedge clk);
        end
        n_total++;
        if (!hit) $display("FAIL mid_reach got no idx 3 beat want one");
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({feat_valid, theta_out, x_ready} !== {1'b0, 17'd0, 1'b0})
            $display("FAIL mid_abort got v=%b th=%h xr=%b want 0 00000 0", feat_valid, theta_out, x_ready);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (x_ready !== 1'b1) $display("FAIL mid_release got xready=%b want 1", x_ready);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (feat_valid) extra++;
            @(negedge clk);
        end
        n_total++;
        if (extra != 0) $display("FAIL mid_nobeats got %0d beats want 0", extra);
        else n_pass++;
        model(16'h0A00);
        drive_vector(16'h0A00, 0);
        n_total++;
        if (o_timeout || ob_idx.size() != NB)
            $display("FAIL mid_fresh_count got %0d to=%b want %0d", ob_idx.size(), o_timeout, NB);
        else n_pass++;
        for (int i = 0; i < ob_idx.size() && i < NB; i++) begin
            n_total++;
            if ({ob_idx[i], ob_out[i], ob_th[i], ob_last[i]} !== {e_idx[i], e_out[i], e_th[i], e_last[i]})
                $display("FAIL mid_fresh%0d got idx=%0d out=%h th=%h want idx=%0d out=%h th=%h",
                         i, ob_idx[i], ob_out[i], ob_th[i], e_idx[i], e_out[i], e_th[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_clamp();
        test_stall();
        test_random();
        test_reset_midvector();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
